// File: rtl/i2s_sample_rx.sv
// i2s_sample_rx: turns an I2S stream, oversampled on clk_i, into SAMPLE_W-bit signed PCM words.
// Latency: sample_valid_o rises 4 clk_i after the raw bclk_i rising edge that carries the word LSB.
// Backpressure: none; the consumer must accept every sample_valid_o strobe.
//
// Build option MONO_MIX_EN: emit one (L+R)>>>1 word per frame instead of one word per slot.
// Ports:
//   clk_i, rst_i                   system clock (>= 4x bclk), async active-high reset
//   bclk_i, lrclk_i, sdata_i       raw I2S inputs (bit clock, word select 0=L/1=R, data)
//   sample_out_o                   last completed PCM word, held until the next strobe
//   sample_valid_o                 one-cycle strobe, sample_out_o updated this cycle
//   sample_right_o                 channel of sample_out_o (0 = left, 1 = right)
//   frame_err_o                    one-cycle strobe, word select moved before a word completed
//   link_lost_o                    level, no bclk rising edge for TIMEOUT clk_i cycles
module i2s_sample_rx #(
  parameter int SAMPLE_W = 16,
  parameter int TIMEOUT  = 1023,
  parameter int CNT_W    = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                bclk_i,
  input  logic                lrclk_i,
  input  logic                sdata_i,
  output logic [SAMPLE_W-1:0] sample_out_o,
  output logic                sample_valid_o,
  output logic                sample_right_o,
  output logic                frame_err_o,
  output logic                link_lost_o
);

  localparam int BCW = $clog2(SAMPLE_W);

  typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_SHIFT, ST_HOLD} state_e;

  // {bclk, lrclk, sdata}: two synchroniser stages, then a history stage. The history
  // stage is registered together with the edge pulse so that lr/sd are the values
  // present when the edge was seen.
  logic [2:0] sync1_q, sync2_q, hist_q;
  logic       rise_q;
  logic       lr, sd;

  logic [CNT_W-1:0]    to_cnt_q, to_cnt_d;
  logic                lost;
  logic                lr_prev_q, lr_seen_q, lr_chg;

  state_e              state_q, state_d;
  logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-2:0] shreg_q, shreg_d;
  logic                chan_q, chan_d;
  logic                shift_en, word_done, slot_err, cnt_zero;
  logic [SAMPLE_W-1:0] word;

  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                valid_q, valid_d, right_q, right_d, ferr_q;

  assign lr       = hist_q[1];
  assign sd       = hist_q[0];
  assign lost     = (to_cnt_q == CNT_W'(TIMEOUT));
  // lr_seen_q stops the first sampled lrclk after reset from looking like a slot edge.
  assign lr_chg   = rise_q & lr_seen_q & (lr ^ lr_prev_q);
  assign cnt_zero = (bit_cnt_q == '0);
  assign word     = {shreg_q, sd};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= {bclk_i, lrclk_i, sdata_i};
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      rise_q  <= sync2_q[2] & ~hist_q[2];
    end
  end

  // Link watchdog: cleared by every bit clock edge, saturates at TIMEOUT.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (rise_q)
      to_cnt_d = '0;
    else if (!lost)
      to_cnt_d = to_cnt_q + CNT_W'(1);
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // FSM next state. A bit clock edge always takes precedence over the watchdog so
  // that the edge which ends a stall is processed normally from IDLE.
  always_comb begin
    state_d = state_q;
    if (rise_q) begin
      unique case (state_q)
        ST_IDLE:  if (lr_chg) state_d = ST_SKIP;
        ST_SKIP:  state_d = ST_SHIFT;
        // LSB and word-select edge on the same bit: finish the word, then start the slot.
        ST_SHIFT: if (cnt_zero) state_d = lr_chg ? ST_SKIP : ST_HOLD;
                  else if (lr_chg) state_d = ST_SKIP;
        ST_HOLD:  if (lr_chg) state_d = ST_SKIP;
        default:  state_d = ST_IDLE;
      endcase
    end else if (lost) begin
      state_d = ST_IDLE;
    end
  end

  // FSM outputs and datapath next state
  always_comb begin
    shift_en  = rise_q && (state_q == ST_SHIFT);
    word_done = shift_en && cnt_zero;
    slot_err  = shift_en && !cnt_zero && lr_chg;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    chan_d    = chan_q;
    if (rise_q && (state_q == ST_SKIP))
      bit_cnt_d = BCW'(SAMPLE_W - 1);
    else if (shift_en && !cnt_zero)
      bit_cnt_d = bit_cnt_q - BCW'(1);
    if (shift_en)
      shreg_d = word[SAMPLE_W-2:0];
    // Channel is the word select value seen on the edge that opens the slot.
    if (rise_q && (state_d == ST_SKIP))
      chan_d = lr;
  end

`ifdef MONO_MIX_EN
  logic [SAMPLE_W-1:0]   left_q, left_d;
  logic                  have_l_q, have_l_d;
  logic signed [SAMPLE_W:0] mix_sum;

  // Left word is parked until its right partner completes; a right word without a
  // parked left (after IDLE or an errored left slot) is dropped.
  always_comb begin
    mix_sum  = $signed({left_q[SAMPLE_W-1], left_q}) + $signed({word[SAMPLE_W-1], word});
    left_d   = left_q;
    have_l_d = have_l_q;
    valid_d  = 1'b0;
    sample_d = sample_q;
    right_d  = 1'b0;
    if (word_done && !chan_q) begin
      left_d   = word;
      have_l_d = 1'b1;
    end else if (word_done && have_l_q) begin
      valid_d  = 1'b1;
      sample_d = mix_sum[SAMPLE_W:1];  // arithmetic >>1, rounds toward -inf
      have_l_d = 1'b0;
    end
    if (slot_err || (lost && !rise_q))
      have_l_d = 1'b0;
  end
`else
  always_comb begin
    valid_d  = word_done;
    sample_d = sample_q;
    right_d  = right_q;
    if (word_done) begin
      sample_d = word;
      right_d  = chan_q;
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q  <= '0;
      lr_prev_q <= 1'b0;
      lr_seen_q <= 1'b0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      chan_q    <= 1'b0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      right_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef MONO_MIX_EN
      left_q    <= '0;
      have_l_q  <= 1'b0;
`endif
    end else begin
      to_cnt_q  <= to_cnt_d;
      if (rise_q) begin
        lr_prev_q <= lr;
        lr_seen_q <= 1'b1;
      end
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      chan_q    <= chan_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      right_q   <= right_d;
      ferr_q    <= slot_err;
`ifdef MONO_MIX_EN
      left_q    <= left_d;
      have_l_q  <= have_l_d;
`endif
    end
  end

  assign sample_out_o   = sample_q;
  assign sample_valid_o = valid_q;
  assign sample_right_o = right_q;
  assign frame_err_o    = ferr_q;
  assign link_lost_o    = lost;

endmodule

// File: tb/tb_i2s_sample_rx.sv
// Bench for i2s_sample_rx: drives I2S slots at clk = 8x bclk, pushes expected words
// into a scoreboard when the LSB edge is driven, and pops/compares on sample_valid.
`timescale 1ns/1ps
module tb_i2s_sample_rx;

  typedef struct {
    logic [15:0] dat;
    logic        right;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bclk = 1'b0;
  logic        lrclk = 1'b0;
  logic        sdata = 1'b0;
  logic [15:0] sample_out;
  logic        sample_valid, sample_right, frame_err, link_lost;

  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          ferr_seen = 0;
  int          exp_ferr = 0;
  exp_t        sbq[$];
  exp_t        mon_e;
  logic [15:0] pend_dat;
  logic        pend_right;

  i2s_sample_rx dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bclk_i         (bclk),
    .lrclk_i        (lrclk),
    .sdata_i        (sdata),
    .sample_out_o   (sample_out),
    .sample_valid_o (sample_valid),
    .sample_right_o (sample_right),
    .frame_err_o    (frame_err),
    .link_lost_o    (link_lost)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One bclk period (8 clk): low half with new lrclk/sdata, then the rising edge.
  task automatic send_bit(input logic lr, input logic d, input logic push);
    exp_t e;
    @(negedge clk);
    bclk  = 1'b0;
    lrclk = lr;
    sdata = d;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    if (push) begin
      e.dat   = pend_dat;
      e.right = pend_right;
      e.cyc   = cyc;
      sbq.push_back(e);
    end
    repeat (3) @(negedge clk);
  endtask

  // Slot: word-select edge bit, one-bit delay bit (driven 1, must be discarded),
  // then ndata bits: the word MSB first, anything past 16 bits is padding.
  task automatic send_slot(input logic ch, input logic [15:0] w, input int ndata,
                           input logic pad, input logic exp_en,
                           input logic [15:0] exp_dat, input logic exp_right);
    pend_dat   = exp_dat;
    pend_right = exp_right;
    send_bit(ch, 1'b0, 1'b0);
    send_bit(ch, 1'b1, 1'b0);
    for (int i = 0; i < ndata; i++) begin
      logic b;
      b = (i < 16) ? w[15-i] : pad;
      send_bit(ch, b, exp_en && (i == 15));
    end
  endtask

  always @(negedge clk) begin
    if (frame_err) ferr_seen++;
    if (sample_valid) begin
      check("sb_nonempty", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        check("sample_out", sample_out, mon_e.dat);
        check("sample_right", sample_right, mon_e.right);
        check("latency", cyc - mon_e.cyc, 4);
        check("valid_err_excl", frame_err, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_sample_out", sample_out, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_right", sample_right, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_link_lost", link_lost, 0);
    rst = 1'b0;
    repeat (3) send_bit(1'b1, 1'b0, 1'b0);   // settle on the right channel

`ifdef MONO_MIX_EN
    send_slot(1'b0, 16'h8000, 16, 1'b0, 1'b0, 16'h0000, 1'b0);
    send_slot(1'b1, 16'h8001, 16, 1'b0, 1'b1, 16'h8000, 1'b0);
    send_slot(1'b0, 16'h0003, 16, 1'b0, 1'b0, 16'h0000, 1'b0);
    send_slot(1'b1, 16'h0000, 16, 1'b0, 1'b1, 16'h0001, 1'b0);
    // -1 + 0 = -1, halved toward -inf stays -1
    send_slot(1'b0, 16'hFFFF, 16, 1'b0, 1'b0, 16'h0000, 1'b0);
    send_slot(1'b1, 16'h0000, 16, 1'b0, 1'b1, 16'hFFFF, 1'b0);
    // errored left slot: the following right word has no partner and is dropped
    send_slot(1'b0, 16'h1111, 10, 1'b0, 1'b0, 16'h0000, 1'b0);
    exp_ferr++;
    send_slot(1'b1, 16'h1234, 16, 1'b0, 1'b0, 16'h0000, 1'b0);
    send_slot(1'b0, 16'h0002, 16, 1'b0, 1'b0, 16'h0000, 1'b0);
    send_slot(1'b1, 16'h0004, 16, 1'b0, 1'b1, 16'h0003, 1'b0);
`else
    // stereo 16-bit slots
    send_slot(1'b0, 16'h1234, 16, 1'b0, 1'b1, 16'h1234, 1'b0);
    send_slot(1'b1, 16'hEDCB, 16, 1'b0, 1'b1, 16'hEDCB, 1'b1);
    // 32-bit slots with padding
    send_slot(1'b0, 16'h7FFF, 32, 1'b1, 1'b1, 16'h7FFF, 1'b0);
    send_slot(1'b1, 16'h8001, 32, 1'b0, 1'b1, 16'h8001, 1'b1);
    // word select moves after 10 bits
    send_slot(1'b0, 16'hABCD, 10, 1'b0, 1'b0, 16'h0000, 1'b0);
    exp_ferr++;
    send_slot(1'b1, 16'hA5A5, 16, 1'b0, 1'b1, 16'hA5A5, 1'b1);
    repeat (8) @(negedge clk);
    check("ferr_after_short_slot", ferr_seen, exp_ferr);
    // bit clock stalls mid-word
    send_slot(1'b0, 16'h1357, 8, 1'b0, 1'b0, 16'h0000, 1'b0);
    repeat (1000) @(negedge clk);
    check("link_lost_early", link_lost, 0);
    repeat (100) @(negedge clk);
    check("link_lost_set", link_lost, 1);
    for (int i = 0; i < 8; i++) send_bit(1'b0, i[0], 1'b0);
    check("link_lost_clear", link_lost, 0);
    send_slot(1'b1, 16'h5A5A, 16, 1'b0, 1'b1, 16'h5A5A, 1'b1);
    // reset in the middle of a word
    send_slot(1'b0, 16'h4444, 8, 1'b0, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_sample_out", sample_out, 0);
    check("midrst_right", sample_right, 0);
    check("midrst_valid", sample_valid, 0);
    check("midrst_frame_err", frame_err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b1, 1'b0);
    send_slot(1'b1, 16'h0BAD, 16, 1'b0, 1'b1, 16'h0BAD, 1'b1);
    send_slot(1'b0, 16'hCAFE, 16, 1'b0, 1'b1, 16'hCAFE, 1'b0);
`endif

    repeat (12) @(negedge clk);
    check("sb_drained", sbq.size(), 0);
    check("ferr_total", ferr_seen, exp_ferr);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
